// File: rtl/temporal_mxu_pkg.sv
// Shared types and helpers for the temporal GEMM engine: FSM states,
// sign/magnitude split and per-cycle chunk selection.
package temporal_mxu_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, BIAS, STREAM, DONE} tge_state_t;

  // Returns {neg, magnitude} of the w-bit two's-complement value in x[w-1:0].
  // The most negative value maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [32:0] signed_mag(input logic [31:0] x, input int w);
    logic [31:0] mask;
    logic        neg;
    logic [31:0] mag;
    mask = (32'd1 << w) - 32'd1;
    neg  = x[w-1];
    mag  = neg ? ((~x + 32'd1) & mask) : (x & mask);
    return {neg, mag};
  endfunction

  function automatic logic [31:0] chunk_min(input logic [31:0] rem, input logic [31:0] cap);
    return (rem < cap) ? rem : cap;
  endfunction

endpackage

// File: rtl/temporal_pe.sv
// One output cell: accumulates +/- chunk*mcand each enabled cycle, where the
// product is formed by shift-add over the chunk bits.
module temporal_pe
  import temporal_mxu_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int STEP_LOG2 = 1,
  parameter int ACC_W     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 neg,
  input  logic [STEP_LOG2:0]   chunk,
  input  logic [BIT_WIDTH-1:0] mcand,
  output logic [ACC_W-1:0]     acc
);

  logic [ACC_W-1:0] mcand_ext;
  logic [ACC_W-1:0] partial [STEP_LOG2+1];
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] prod;

  assign mcand_ext = {{(ACC_W-BIT_WIDTH){mcand[BIT_WIDTH-1]}}, mcand};

  for (genvar gi = 0; gi <= STEP_LOG2; gi++) begin : g_partial
    assign partial[gi] = chunk[gi] ? (mcand_ext << gi) : '0;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i <= STEP_LOG2; i++) begin
      sum = sum + partial[i];
    end
    prod = neg ? (~sum + 1'b1) : sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule

// File: rtl/temporal_gemm_engine.sv
// Temporal matrix unit: OUT = beta*C + A*B (+ OUT when acc_en), consuming each
// multiplier magnitude in chunks of up to 2^STEP_LOG2 per cycle.
module temporal_gemm_engine
  import temporal_mxu_pkg::*;
#(
  parameter int DIM       = 16,
  parameter int BIT_WIDTH = 4,
  parameter int STEP_LOG2 = 1,
  parameter int ACC_W     = 2*BIT_WIDTH + $clog2(DIM+1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         acc_en,
  input  logic [DIM*DIM*BIT_WIDTH-1:0] A,
  input  logic [DIM*DIM*BIT_WIDTH-1:0] B,
  input  logic [DIM*DIM*BIT_WIDTH-1:0] C,
  input  logic [BIT_WIDTH-1:0]         beta,
  output logic                         busy,
  output logic                         out_valid,
  output logic [DIM*DIM*ACC_W-1:0]     out
);

  localparam int CW = STEP_LOG2 + 1;
  localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;

  tge_state_t state;

  logic [DIM*DIM*BIT_WIDTH-1:0] a_reg, b_reg, c_reg;
  logic [BIT_WIDTH-1:0]         beta_reg;
  logic                         acc_reg;
  logic [KW-1:0]                k_reg;
  logic [BIT_WIDTH-1:0]         rem_reg [DIM];
  logic                         neg_reg [DIM];

  logic [CW-1:0]        chunk     [DIM];
  logic [BIT_WIDTH-1:0] rem_next  [DIM];
  logic [KW-1:0]        load_k;
  logic [BIT_WIDTH-1:0] mult_next [DIM];
  logic [32:0]          smag      [DIM];
  logic [BIT_WIDTH-1:0] rem_load  [DIM];
  logic                 neg_load  [DIM];
  logic                 all_zero;

  logic pe_en, pe_clr;

  // Per-row chunk selection and the phase-end detect on the post-chunk remainder.
  always_comb begin
    all_zero = 1'b1;
    for (int r = 0; r < DIM; r++) begin
      chunk[r]    = CW'(chunk_min(32'(rem_reg[r]), 32'd1 << STEP_LOG2));
      rem_next[r] = rem_reg[r] - BIT_WIDTH'(chunk[r]);
      if (rem_next[r] != '0) all_zero = 1'b0;
    end
  end

  // Multipliers of the next phase: beta after LOAD, A[row][0] after BIAS, A[row][k+1] otherwise.
  always_comb begin
    load_k = (state == BIAS) ? '0 : k_reg + 1'b1;
    for (int r = 0; r < DIM; r++) begin
      mult_next[r] = (state == LOAD) ? beta_reg
                                     : a_reg[(r*DIM + int'(load_k))*BIT_WIDTH +: BIT_WIDTH];
      smag[r]      = signed_mag(32'(mult_next[r]), BIT_WIDTH);
      rem_load[r]  = smag[r][BIT_WIDTH-1:0];
      neg_load[r]  = smag[r][32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      k_reg     <= '0;
      for (int r = 0; r < DIM; r++) begin
        rem_reg[r] <= '0;
        neg_reg[r] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          // busy is still high during the out_valid cycle, so a start there is dropped
          if (start && !busy) begin
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          for (int r = 0; r < DIM; r++) begin
            rem_reg[r] <= rem_load[r];
            neg_reg[r] <= neg_load[r];
          end
          state <= BIAS;
        end
        BIAS, STREAM: begin
          for (int r = 0; r < DIM; r++) rem_reg[r] <= rem_next[r];
          if (all_zero) begin
            if (state == STREAM && k_reg == KW'(DIM-1)) begin
              state <= DONE;
            end else begin
              for (int r = 0; r < DIM; r++) begin
                rem_reg[r] <= rem_load[r];
                neg_reg[r] <= neg_load[r];
              end
              k_reg <= load_k;
              state <= STREAM;
            end
          end
        end
        DONE: begin
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && start && !busy) begin
      a_reg    <= A;
      b_reg    <= B;
      c_reg    <= C;
      beta_reg <= beta;
      acc_reg  <= acc_en;
    end
  end

  assign pe_en  = (state == BIAS) || (state == STREAM);
  assign pe_clr = (state == LOAD) && !acc_reg;

  for (genvar gi = 0; gi < DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < DIM; gj++) begin : g_col
      logic [BIT_WIDTH-1:0] mcand;
      logic [ACC_W-1:0]     acc;

      assign mcand = (state == BIAS) ? c_reg[(gi*DIM + gj)*BIT_WIDTH +: BIT_WIDTH]
                                     : b_reg[(int'(k_reg)*DIM + gj)*BIT_WIDTH +: BIT_WIDTH];

      temporal_pe #(
        .BIT_WIDTH(BIT_WIDTH),
        .STEP_LOG2(STEP_LOG2),
        .ACC_W    (ACC_W)
      ) u_pe (
        .clk  (clk),
        .reset(reset),
        .en   (pe_en),
        .clr  (pe_clr),
        .neg  (neg_reg[gi]),
        .chunk(chunk[gi]),
        .mcand(mcand),
        .acc  (acc)
      );

      assign out[(gi*DIM + gj)*ACC_W +: ACC_W] = acc;
    end
  end

endmodule

// File: tb/tb_temporal_gemm_engine.sv
// Directed bench for temporal_gemm_engine at DIM=2, BIT_WIDTH=4 with
// STEP_LOG2=1 (u_dut) and STEP_LOG2=0 (u_dut0).
module tb_temporal_gemm_engine;

  localparam int DIM = 2;
  localparam int BW  = 4;
  localparam int AW  = 2*BW + $clog2(DIM+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset, start, start0, acc_en;
  logic [DIM*DIM*BW-1:0]  A, B, C;
  logic [BW-1:0]          beta;
  logic                   busy, busy0, ov, ov0;
  logic [DIM*DIM*AW-1:0]  out, out0;

  int checks   = 0;
  int failures = 0;

  temporal_gemm_engine #(.DIM(DIM), .BIT_WIDTH(BW), .STEP_LOG2(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .acc_en(acc_en),
    .A(A), .B(B), .C(C), .beta(beta),
    .busy(busy), .out_valid(ov), .out(out)
  );

  temporal_gemm_engine #(.DIM(DIM), .BIT_WIDTH(BW), .STEP_LOG2(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .acc_en(acc_en),
    .A(A), .B(B), .C(C), .beta(beta),
    .busy(busy0), .out_valid(ov0), .out(out0)
  );

  function automatic logic [15:0] pack4(input int e00, input int e01, input int e10, input int e11);
    logic [3:0] v0, v1, v2, v3;
    v0 = 4'(e00); v1 = 4'(e01); v2 = 4'(e10); v3 = 4'(e11);
    return {v3, v2, v1, v0};
  endfunction

  function automatic int elem(input logic [DIM*DIM*AW-1:0] v, input int idx);
    logic signed [AW-1:0] e;
    e = v[idx*AW +: AW];
    return int'(e);
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Accept one tile on the selected DUT, scramble the inputs afterwards, and
  // check busy, latency, the one-cycle pulse and the four results.
  task automatic run_tile(input string tag, input bit sel0, input bit acc, input bit poke,
                          input int exp_lat, input int e00, input int e01, input int e10, input int e11);
    int lat;
    logic [DIM*DIM*AW-1:0] res;
    @(negedge clk);
    if (sel0) start0 = 1'b1; else start = 1'b1;
    acc_en = acc;
    @(posedge clk); #1;
    start = 1'b0; start0 = 1'b0; acc_en = 1'b0;
    A = ~A; B = ~B; C = ~C; beta = ~beta;
    check({tag, "_busy"}, int'(sel0 ? busy0 : busy), 1);
    lat = 0;
    while (!(sel0 ? ov0 : ov) && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (poke) start = (lat == 2 || lat == 4);
    end
    start = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    res = sel0 ? out0 : out;
    check({tag, "_o00"}, elem(res, 0), e00);
    check({tag, "_o01"}, elem(res, 1), e01);
    check({tag, "_o10"}, elem(res, 2), e10);
    check({tag, "_o11"}, elem(res, 3), e11);
    @(posedge clk); #1;
    check({tag, "_pulse"}, int'(sel0 ? ov0 : ov), 0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b1; start0 = 1'b1; acc_en = 1'b0;
    A = '0; B = '0; C = '0; beta = '0;

    // Reset held two cycles with start asserted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_ov", int'(ov), 0);
    check("rst_out", int'(out == '0), 1);
    check("rst_busy0", int'(busy0), 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; start0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_idle", int'(busy), 0);

    // Identity: out = B, latency 2+1+1+1.
    A = pack4(1, 0, 0, 1); B = pack4(1, 2, 3, 4); C = '0; beta = '0;
    run_tile("ident", 1'b0, 1'b0, 1'b0, 5, 1, 2, 3, 4);

    // Accumulate the same product; starts during busy and in the DONE cycle are dropped.
    A = pack4(1, 0, 0, 1); B = pack4(1, 2, 3, 4); C = '0; beta = '0;
    run_tile("accum", 1'b0, 1'b1, 1'b1, 5, 2, 4, 6, 8);
    repeat (3) @(posedge clk);
    #1;
    check("noqueue_busy", int'(busy), 0);
    check("hold_out", elem(out, 3), 8);

    // Extreme signs: (-8)*7*2 = -112, latency 2+1+4+4 and 2+1+8+8 in pure unary.
    A = pack4(-8, -8, -8, -8); B = pack4(7, 7, 7, 7); C = '0; beta = '0;
    run_tile("xsign", 1'b0, 1'b0, 1'b0, 11, -112, -112, -112, -112);
    A = pack4(-8, -8, -8, -8); B = pack4(7, 7, 7, 7); C = '0; beta = '0;
    run_tile("xsign0", 1'b1, 1'b0, 1'b0, 19, -112, -112, -112, -112);

    // Bias only: -3*5 = -15, latency 2+2+1+1.
    A = '0; B = pack4(7, 7, 7, 7); C = pack4(5, 5, 5, 5); beta = 4'hD;
    run_tile("bias", 1'b0, 1'b0, 1'b0, 6, -15, -15, -15, -15);

    // Abort with reset in the second STREAM cycle.
    A = pack4(-8, -8, -8, -8); B = pack4(7, 7, 7, 7); C = '0; beta = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_mid", elem(out, 0), -14);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_out", int'(out == '0), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_ov", int'(ov), 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ov) seen++;
    end
    check("abort_nov", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
